// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_e : controller states (IDLE, RUN, DONE)
//   CNT_W       : iteration counter width (covers up to 64 iterations)
//   step_ok     : legal quotient-bits-per-cycle values
//   most_neg    : most-negative two's complement value of width w, sign-extended to 64 bits
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   localparam int CNT_W = 7;

   function automatic bit step_ok(input int step);
      return (step == 1) || (step == 2) || (step == 4);
   endfunction

   function automatic logic [63:0] most_neg(input int w);
      return ~((64'd1 << (w - 1)) - 64'd1);
   endfunction

endpackage

// File: rtl/div_step.sv
// Combinational restoring division stage retiring STEP quotient bits.
//   rem_in   : partial remainder (always < dsr)
//   dvd_bits : next STEP dividend bits, MSB first
//   dsr      : divisor magnitude
//   rem_out  : partial remainder after STEP shift-subtract steps
//   q_bits   : quotient bits produced, MSB first
module div_step #(
   parameter int XLEN = 64,
   parameter int STEP = 1
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [STEP-1:0] dvd_bits,
   input  logic [XLEN-1:0] dsr,
   output logic [XLEN-1:0] rem_out,
   output logic [STEP-1:0] q_bits
);

   // One extra bit: the shifted remainder can exceed XLEN bits when the
   // divisor magnitude is close to 2^XLEN.
   logic [XLEN:0]   trial;
   logic [XLEN-1:0] part;

   always_comb begin
      part   = rem_in;
      trial  = '0;
      q_bits = '0;
      for (int i = STEP - 1; i >= 0; i--) begin
         trial = {part, dvd_bits[i]};
         if (trial >= {1'b0, dsr}) begin
            trial     = trial - {1'b0, dsr};
            q_bits[i] = 1'b1;
         end
         part = trial[XLEN-1:0];
      end
      rem_out = part;
   end

endmodule

// File: rtl/iter_divider.sv
// Iterative signed/unsigned integer divider with valid/ready on both sides.
//   clk, reset (async, active low)
//   in_valid/in_ready, in_a, in_b, div_signed, is_word : operand request
//   flush                                              : synchronous abort
//   out_valid/out_ready, quotient, remainder           : result
//
// state | meaning
// IDLE  | waiting for an operand request, in_ready high
// RUN   | STEP shift-subtract steps per cycle on magnitudes
// DONE  | signed/word fix-up applied, result held until out_ready
module iter_divider
   import div_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int STEP = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic            div_signed,
   input  logic            is_word,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   if (!step_ok(STEP) || !((XLEN == 32) || (XLEN == 64))) begin : g_bad_param
      $error("iter_divider: unsupported XLEN/STEP");
   end

   localparam int              PAD     = XLEN - 32;
   localparam logic [CNT_W-1:0] LAST_X = CNT_W'(XLEN / STEP - 1);
   localparam logic [CNT_W-1:0] LAST_W = CNT_W'(32 / STEP - 1);
   localparam logic [63:0]      MN64   = most_neg(XLEN);
   localparam logic [63:0]      MN32   = most_neg(32);
   localparam logic [XLEN-1:0]  HI     = ~XLEN'(32'hFFFF_FFFF);

   // Extend a 32-bit value to XLEN; hi-fill only when s and bit 31 are set.
   function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic s);
      return XLEN'(v) | ((s && v[31]) ? HI : '0);
   endfunction

   div_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  rem, dvd, dsr;
   logic             neg_q, neg_r, word_q;

   logic             word_op, sa, sb, div0, ovf;
   logic [XLEN-1:0]  a_ext, b_ext, abs_a, abs_b;
   logic [XLEN-1:0]  rem_nxt, dvd_nxt, q_s, r_s, q_fin, r_fin;
   logic [STEP-1:0]  q_bits;
   logic             last;

   assign word_op = (XLEN == 64) && is_word;
   assign a_ext   = word_op ? ext32(in_a[31:0], div_signed) : in_a;
   assign b_ext   = word_op ? ext32(in_b[31:0], div_signed) : in_b;
   assign sa      = div_signed && a_ext[XLEN-1];
   assign sb      = div_signed && b_ext[XLEN-1];
   assign abs_a   = sa ? -a_ext : a_ext;
   assign abs_b   = sb ? -b_ext : b_ext;
   assign div0    = (b_ext == '0);
   assign ovf     = div_signed && (b_ext == '1) &&
                    (a_ext == (word_op ? MN32[XLEN-1:0] : MN64[XLEN-1:0]));

   div_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
      .rem_in   (rem),
      .dvd_bits (dvd[XLEN-1 -: STEP]),
      .dsr      (dsr),
      .rem_out  (rem_nxt),
      .q_bits   (q_bits)
   );

   // Word operands sit in the top 32 bits of dvd, so after 32 shifts the
   // quotient lands in the low 32 bits.
   assign dvd_nxt = {dvd[XLEN-1-STEP:0], q_bits};
   assign q_s     = neg_q ? -dvd_nxt : dvd_nxt;
   assign r_s     = neg_r ? -rem_nxt : rem_nxt;
   assign q_fin   = word_q ? ext32(q_s[31:0], 1'b1) : q_s;
   assign r_fin   = word_q ? ext32(r_s[31:0], 1'b1) : r_s;
   assign last    = (cnt == (word_q ? LAST_W : LAST_X));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rem       <= '0;
         dvd       <= '0;
         dsr       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         word_q    <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else if (flush) begin
         state     <= IDLE;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  neg_q    <= sa ^ sb;
                  neg_r    <= sa;
                  word_q   <= word_op;
                  cnt      <= '0;
                  if (div0) begin
                     quotient  <= '1;
                     remainder <= word_op ? ext32(in_a[31:0], 1'b1) : in_a;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else if (ovf) begin
                     quotient  <= a_ext;
                     remainder <= '0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     rem   <= '0;
                     dvd   <= word_op ? (abs_a << PAD) : abs_a;
                     dsr   <= abs_b;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               rem <= rem_nxt;
               dvd <= dvd_nxt;
               cnt <= cnt + 1'b1;
               if (last) begin
                  quotient  <= q_fin;
                  remainder <= r_fin;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: STEP=1 and STEP=4 instances (XLEN=64)
// driven with the same operands, expected values computed by hand.
module tb_iter_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, div_signed, is_word, flush, out_ready;
   logic [63:0] in_a, in_b;
   logic        in_ready1, out_valid1, in_ready4, out_valid4;
   logic [63:0] quotient1, remainder1, quotient4, remainder4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   iter_divider #(.XLEN(64), .STEP(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .in_a(in_a), .in_b(in_b), .div_signed(div_signed), .is_word(is_word),
      .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
      .quotient(quotient1), .remainder(remainder1)
   );

   iter_divider #(.XLEN(64), .STEP(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
      .in_a(in_a), .in_b(in_b), .div_signed(div_signed), .is_word(is_word),
      .flush(flush), .out_valid(out_valid4), .out_ready(out_ready),
      .quotient(quotient4), .remainder(remainder4)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called #1 after an edge with both instances idle.
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic sgn, input logic wrd,
                         input logic [63:0] eq, input logic [63:0] er,
                         input int el1, input int el4, input int hold);
      int lat1, lat4;
      in_a = a; in_b = b; div_signed = sgn; is_word = wrd; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = ~a; in_b = b + 64'd3; div_signed = ~sgn; is_word = ~wrd;
      lat1 = 0; lat4 = 0;
      for (int n = 1; n <= 300; n++) begin
         if (out_valid1 && lat1 == 0) lat1 = n;
         if (out_valid4 && lat4 == 0) lat4 = n;
         if (lat1 != 0 && lat4 != 0) break;
         @(posedge clk); #1;
      end
      chk({tag, "_lat1"}, 64'(lat1), 64'(el1));
      chk({tag, "_lat4"}, 64'(lat4), 64'(el4));
      chk({tag, "_q1"}, quotient1, eq);
      chk({tag, "_r1"}, remainder1, er);
      chk({tag, "_q4"}, quotient4, eq);
      chk({tag, "_r4"}, remainder4, er);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_ov"}, 64'(out_valid1), 64'd1);
         chk({tag, "_hold_ir"}, 64'(in_ready1), 64'd0);
         chk({tag, "_hold_q"}, quotient1, eq);
         chk({tag, "_hold_r"}, remainder1, er);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_ir_after"}, {62'd0, in_ready1, in_ready4}, 64'd3);
      chk({tag, "_ov_after"}, {62'd0, out_valid1, out_valid4}, 64'd0);
   endtask

   initial begin
      logic [63:0] ra, rb, rq, rr;
      logic        rs;
      reset = 1'b0; in_valid = 1'b0; div_signed = 1'b0; is_word = 1'b0;
      flush = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
      #12;
      chk("rst_ov", 64'(out_valid1), 64'd0);
      chk("rst_q", quotient1, 64'd0);
      chk("rst_r", remainder1, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_ir", {62'd0, in_ready1, in_ready4}, 64'd3);

      run_op("u100_7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65, 17, 0);
      run_op("s_m7_2", -64'sd7, 64'd2, 1'b1, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65, 17, 0);
      run_op("s_7_m2", 64'd7, -64'sd2, 1'b1, 1'b0, -64'sd3, 64'd1, 65, 17, 0);
      run_op("u5_0", 64'd5, 64'd0, 1'b0, 1'b0, '1, 64'd5, 1, 1, 0);
      run_op("s5_0", 64'd5, 64'd0, 1'b1, 1'b0, '1, 64'd5, 1, 1, 0);
      run_op("s_ovf", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0,
             64'h8000_0000_0000_0000, 64'd0, 1, 1, 0);
      run_op("w_s", 64'h1234_5678_8000_0000, 64'd2, 1'b1, 1'b1,
             64'hFFFF_FFFF_C000_0000, 64'd0, 33, 9, 0);
      run_op("w_u", 64'h1234_5678_8000_0000, 64'd2, 1'b0, 1'b1,
             64'h0000_0000_4000_0000, 64'd0, 33, 9, 0);
      run_op("w_ovf", 64'h1111_1111_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
             64'hFFFF_FFFF_8000_0000, 64'd0, 1, 1, 0);
      run_op("w_div0", 64'h0000_0000_DEAD_BEEF, 64'h0000_0001_0000_0000, 1'b0, 1'b1,
             '1, 64'hFFFF_FFFF_DEAD_BEEF, 1, 1, 0);
      run_op("u_max_16", '1, 64'h10, 1'b0, 1'b0,
             64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 65, 17, 0);
      run_op("u_max_maxm1", '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0,
             64'd1, 64'd1, 65, 17, 0);
      run_op("hold", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65, 17, 10);

      // flush together with in_valid must not accept (5/0 would finish in one cycle)
      in_a = 64'd5; in_b = 64'd0; div_signed = 1'b0; is_word = 1'b0;
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("flushblk_ov", {62'd0, out_valid1, out_valid4}, 64'd0);
      chk("flushblk_ir", {62'd0, in_ready1, in_ready4}, 64'd3);
      @(posedge clk); #1;
      chk("flushblk_ov2", {62'd0, out_valid1, out_valid4}, 64'd0);

      // flush in RUN cycle 20
      in_a = 64'd100; in_b = 64'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      chk("flush_pre_ir", 64'(in_ready1), 64'd0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_ov", {62'd0, out_valid1, out_valid4}, 64'd0);
      chk("flush_ir", {62'd0, in_ready1, in_ready4}, 64'd3);
      run_op("after_flush", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65, 17, 0);

      // reset mid-RUN (STEP=4 instance already holding its result)
      in_a = 64'd100; in_b = 64'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("rstrun_ov", {62'd0, out_valid1, out_valid4}, 64'd0);
      chk("rstrun_q", quotient1 | quotient4, 64'd0);
      chk("rstrun_r", remainder1 | remainder4, 64'd0);
      #2;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rstrun_ir", {62'd0, in_ready1, in_ready4}, 64'd3);
      run_op("after_rst", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65, 17, 0);

      // random full-width operands checked against the simulator's own / and %
      for (int k = 0; k < 6; k++) begin
         rs = k[0];
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom} >> $urandom_range(62, 0);
         if (rb == 64'd0) rb = 64'd3;
         if (rs && ra == 64'h8000_0000_0000_0000 && rb == '1) ra = 64'd1;
         if (rs) begin
            rq = $signed(ra) / $signed(rb);
            rr = $signed(ra) % $signed(rb);
         end else begin
            rq = ra / rb;
            rr = ra % rb;
         end
         run_op($sformatf("rand%0d", k), ra, rb, rs, 1'b0, rq, rr, 65, 17, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
